// File: rtl/noc_pkg.sv
// Shared packet layout, packet type encoding and receive FSM states for the NoC receive path.
package noc_pkg;

   localparam int PKT_WIDTH = 39;
   localparam int DEST_W    = 4;
   localparam int SRC_W     = 4;
   localparam int TAG_W     = 5;
   localparam int PAYLOAD_W = 24;

   typedef enum logic [1:0] {
      PKT_READ  = 2'b00,
      PKT_WRITE = 2'b01,
      PKT_RESP  = 2'b10,
      PKT_MSG   = 2'b11
   } pkt_type_e;

   // MSB-first field order matches the wire format: type, dest, src, tag, payload.
   typedef struct packed {
      pkt_type_e              ptype;
      logic [DEST_W-1:0]      dest;
      logic [SRC_W-1:0]       src;
      logic [TAG_W-1:0]       tag;
      logic [PAYLOAD_W-1:0]   payload;
   } packet_t;

   typedef enum logic [1:0] {
      S_RESYNC = 2'b00,
      S_IDLE   = 2'b01,
      S_ACKED  = 2'b10
   } rx_state_e;

   function automatic packet_t unpack_pkt(input logic [PKT_WIDTH-1:0] raw);
      return packet_t'(raw);
   endfunction

endpackage

// File: rtl/noc_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; all stages clear on reset.
module noc_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous level through the flop chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{1'b0}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/noc_pkt_rx.sv
// Receive end of a 4-phase bundled-data NoC channel: sync in_req, buffer packets, decode the head.
// Optional destination filter enabled by defining NOC_RX_ADDR_FILTER_EN.
module noc_pkt_rx
   import noc_pkg::*;
#(
   parameter int         WIDTH       = PKT_WIDTH,
   parameter int         DEPTH       = 4,
   parameter int         SYNC_STAGES = 2,
   parameter logic [3:0] MY_ADDR     = 4'h0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_req,
   input  logic [WIDTH-1:0]  in_data,
   output logic              in_ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_type,
   output logic [3:0]        out_dest,
   output logic [3:0]        out_src,
   output logic [4:0]        out_tag,
   output logic [23:0]       out_payload,
   output logic [15:0]       rx_count,
   output logic [7:0]        drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(SYNC_STAGES + 1);

`ifdef NOC_RX_ADDR_FILTER_EN
   localparam logic FILTER_EN = 1'b1;
`else
   localparam logic FILTER_EN = 1'b0;
`endif

   logic          req_s;
   rx_state_e     state_q, state_d;
   logic          ack_q, ack_d;
   logic [SW-1:0] settle_q, settle_d;
   packet_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [15:0]   rx_count_q;
   logic [7:0]    drop_count_q;
   packet_t       pkt_in_s, head_s;
   logic          full_s, empty_s, push_s, pop_s, drop_s, mismatch_s;

   noc_bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d_i (in_req),
      .q_o (req_s)
   );

   assign pkt_in_s   = unpack_pkt(in_data);
   assign full_s     = (count_q == CW'(DEPTH));
   assign empty_s    = (count_q == {CW{1'b0}});
   assign pop_s      = !empty_s && out_ready;
   assign mismatch_s = FILTER_EN && (pkt_in_s.dest != MY_ADDR);

   // Handshake FSM; after reset the synchronizer must refill before req_s is trusted.
   always_comb begin
      state_d  = state_q;
      ack_d    = ack_q;
      settle_d = settle_q;
      push_s   = 1'b0;
      drop_s   = 1'b0;
      case (state_q)
         S_RESYNC: begin
            if (settle_q != SW'(SYNC_STAGES)) begin
               settle_d = settle_q + 1'b1;
            end else if (!req_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESYNC;
            end
         end
         S_IDLE: begin
            if (req_s && mismatch_s) begin
               drop_s  = 1'b1;
               ack_d   = 1'b1;
               state_d = S_ACKED;
            end else if (req_s && !full_s) begin
               push_s  = 1'b1;
               ack_d   = 1'b1;
               state_d = S_ACKED;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACKED: begin
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_ACKED;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = S_RESYNC;
         end
      endcase
   end

   // FSM, acknowledge and settle counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_RESYNC;
         ack_q    <= 1'b0;
         settle_q <= {SW{1'b0}};
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         settle_q <= settle_d;
      end
   end

   // FIFO storage; contents are don't-care until the pointers say otherwise.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= pkt_in_s;
      end
   end

   // FIFO pointers, occupancy and statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= {AW{1'b0}};
         rd_ptr_q     <= {AW{1'b0}};
         count_q      <= {CW{1'b0}};
         rx_count_q   <= 16'h0000;
         drop_count_q <= 8'h00;
      end else begin
         if (push_s) begin
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            rx_count_q <= rx_count_q + 16'h0001;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (drop_s && (drop_count_q != 8'hFF)) begin
            drop_count_q <= drop_count_q + 8'h01;
         end
      end
   end

   assign head_s      = empty_s ? packet_t'({PKT_WIDTH{1'b0}}) : mem_q[rd_ptr_q];
   assign in_ack      = ack_q;
   assign out_valid   = !empty_s;
   assign out_type    = head_s.ptype;
   assign out_dest    = head_s.dest;
   assign out_src     = head_s.src;
   assign out_tag     = head_s.tag;
   assign out_payload = head_s.payload;
   assign rx_count    = rx_count_q;
   assign drop_count  = drop_count_q;

endmodule
